// File: rtl/gate_vector_sequencer_if.sv
// gate_vector_sequencer_if: run control, stimulus, gate observations and result bundle
interface gate_vector_sequencer_if #(parameter int ERR_W = 8);
    logic             start;
    logic             a;
    logic             b;
    logic             xor_g;
    logic             and_g;
    logic             nand_g;
    logic             not_g;
    logic             or_g;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [4:0]       err_flags;
    logic [1:0]       first_fail;
    logic             fail_seen;
    modport master (
        output start, xor_g, and_g, nand_g, not_g, or_g,
        input  a, b, busy, done, pass, err_count, err_flags, first_fail, fail_seen
    );
    modport slave (
        input  start, xor_g, and_g, nand_g, not_g, or_g,
        output a, b, busy, done, pass, err_count, err_flags, first_fail, fail_seen
    );
endinterface

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: steps a/b through 00,01,10,11, holds each vector, checks the gate truth table
module gate_vector_sequencer #(
    parameter int HOLD_CYCLES = 10,
    parameter int LOOPS       = 1,
    parameter int ERR_W       = 8
) (
    input logic                    clk,
    input logic                    rst,
    gate_vector_sequencer_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t           state_q;
    logic [1:0]       vec_q;
    logic [HW-1:0]    hold_q;
    logic [LW-1:0]    loop_q;
    logic             busy_q, done_q, pass_q, seen_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [4:0]       flags_q, exp_v, mis;
    logic [1:0]       first_q;
    logic             last, fin;
    always_comb begin
        exp_v = {vec_q[1] | vec_q[0], ~vec_q[1], ~(vec_q[1] & vec_q[0]), vec_q[1] & vec_q[0], vec_q[1] ^ vec_q[0]};
        mis   = {bus.or_g, bus.not_g, bus.nand_g, bus.and_g, bus.xor_g} ^ exp_v;
        last  = hold_q == HW'(HOLD_CYCLES - 1);
        fin   = last && vec_q == 2'd3 && loop_q == LW'(LOOPS - 1);
        err_d = (|mis && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            loop_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            flags_q <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else if (state_q != DRIVE) begin
            if (bus.start) begin
                state_q <= DRIVE;
                vec_q   <= '0;
                hold_q  <= '0;
                loop_q  <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                err_q   <= '0;
                flags_q <= '0;
                first_q <= '0;
                seen_q  <= 1'b0;
            end
        end else if (!last) begin
            hold_q <= hold_q + HW'(1);
        end else begin
            hold_q <= '0;
            if (|mis) begin
                err_q   <= err_d;
                flags_q <= flags_q | mis;
                if (!seen_q) begin
                    first_q <= vec_q;
                    seen_q  <= 1'b1;
                end
            end
            // a/b stay on the final vector once the run completes
            if (fin) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= err_d == '0;
            end else begin
                vec_q <= vec_q + 2'd1;
                if (vec_q == 2'd3) loop_q <= loop_q + LW'(1);
            end
        end
    end
    assign bus.a          = vec_q[1];
    assign bus.b          = vec_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.err_flags  = flags_q;
    assign bus.first_fail = first_q;
    assign bus.fail_seen  = seen_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: directed scenarios on three sequencer configurations with modelled gate blocks
module tb_gate_vector_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stuck0 = 1'b0;
    int   tests = 0;
    int   failed = 0;
    always #5 clk = ~clk;
    gate_vector_sequencer_if #(.ERR_W(8)) i0 ();
    gate_vector_sequencer_if #(.ERR_W(2)) i1 ();
    gate_vector_sequencer_if #(.ERR_W(8)) i2 ();
    gate_vector_sequencer #(.HOLD_CYCLES(10), .LOOPS(1), .ERR_W(8)) d0 (.clk(clk), .rst(rst), .bus(i0.slave));
    gate_vector_sequencer #(.HOLD_CYCLES(3), .LOOPS(4), .ERR_W(2)) d1 (.clk(clk), .rst(rst), .bus(i1.slave));
    gate_vector_sequencer #(.HOLD_CYCLES(2), .LOOPS(2), .ERR_W(8)) d2 (.clk(clk), .rst(rst), .bus(i2.slave));
    // d0: golden, or xor stuck at 0
    assign i0.xor_g  = stuck0 ? 1'b0 : i0.a ^ i0.b;
    assign i0.and_g  = i0.a & i0.b;
    assign i0.nand_g = ~(i0.a & i0.b);
    assign i0.not_g  = ~i0.a;
    assign i0.or_g   = i0.a | i0.b;
    // d1: every output inverted
    assign i1.xor_g  = ~(i1.a ^ i1.b);
    assign i1.and_g  = ~(i1.a & i1.b);
    assign i1.nand_g = i1.a & i1.b;
    assign i1.not_g  = i1.a;
    assign i1.or_g   = ~(i1.a | i1.b);
    // d2: golden
    assign i2.xor_g  = i2.a ^ i2.b;
    assign i2.and_g  = i2.a & i2.b;
    assign i2.nand_g = ~(i2.a & i2.b);
    assign i2.not_g  = ~i2.a;
    assign i2.or_g   = i2.a | i2.b;

    task automatic pulse(input int which);
        @(posedge clk);
        #1;
        if (which == 0) i0.start = 1'b1; else if (which == 1) i1.start = 1'b1; else i2.start = 1'b1;
        @(posedge clk);
        #1;
        i0.start = 1'b0;
        i1.start = 1'b0;
        i2.start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({i0.a, i0.b, i0.busy, i0.done, i0.pass, i0.err_count, i0.err_flags, i0.first_fail, i0.fail_seen} !== '0) begin
            failed++;
            $display("FAIL reset_d0 got a=%b b=%b busy=%b done=%b pass=%b err=%0d flags=%b first=%0d seen=%b, want all 0",
                     i0.a, i0.b, i0.busy, i0.done, i0.pass, i0.err_count, i0.err_flags, i0.first_fail, i0.fail_seen);
        end
        tests++;
        if ({i1.busy, i1.done, i1.err_count, i2.busy, i2.done, i2.err_count} !== '0) begin
            failed++;
            $display("FAIL reset_d1d2 got busy=%b/%b done=%b/%b err=%0d/%0d, want 0", i1.busy, i2.busy, i1.done, i2.done, i1.err_count, i2.err_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_golden;
        pulse(0);
        for (int c = 0; c < 40; c++) begin
            tests++;
            if (i0.busy !== 1'b1 || {i0.a, i0.b} !== 2'(c / 10)) begin
                failed++;
                $display("FAIL golden_step c=%0d got busy=%b ab=%b%b, want busy=1 ab=%b", c, i0.busy, i0.a, i0.b, 2'(c / 10));
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if ({i0.busy, i0.done, i0.pass, i0.err_count, i0.a, i0.b} !== {1'b0, 1'b1, 1'b1, 8'd0, 2'b11}) begin
            failed++;
            $display("FAIL golden_done got busy=%b done=%b pass=%b err=%0d ab=%b%b, want 0 1 1 0 11",
                     i0.busy, i0.done, i0.pass, i0.err_count, i0.a, i0.b);
        end
    endtask

    task automatic test_xor_stuck;
        stuck0 = 1'b1;
        pulse(0);
        repeat (39) @(posedge clk);
        #1;
        tests++;
        if (i0.busy !== 1'b1 || i0.done !== 1'b0) begin
            failed++;
            $display("FAIL stuck_last_cycle got busy=%b done=%b, want 1 0", i0.busy, i0.done);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({i0.done, i0.pass, i0.err_count, i0.err_flags, i0.first_fail, i0.fail_seen} !== {1'b1, 1'b0, 8'd2, 5'b00001, 2'd1, 1'b1}) begin
            failed++;
            $display("FAIL stuck_result got done=%b pass=%b err=%0d flags=%b first=%0d seen=%b, want 1 0 2 00001 1 1",
                     i0.done, i0.pass, i0.err_count, i0.err_flags, i0.first_fail, i0.fail_seen);
        end
    endtask

    task automatic test_reset_mid;
        stuck0 = 1'b1;
        pulse(0);
        repeat (24) @(posedge clk);
        #1;
        tests++;
        if ({i0.a, i0.b} !== 2'b10 || i0.err_count !== 8'd1) begin
            failed++;
            $display("FAIL midrun_pre got ab=%b%b err=%0d, want 10 1", i0.a, i0.b, i0.err_count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({i0.a, i0.b, i0.busy, i0.done, i0.err_count, i0.fail_seen} !== '0) begin
            failed++;
            $display("FAIL midrun_reset got ab=%b%b busy=%b done=%b err=%0d seen=%b, want all 0",
                     i0.a, i0.b, i0.busy, i0.done, i0.err_count, i0.fail_seen);
        end
        @(negedge clk);
        rst = 1'b0;
        stuck0 = 1'b0;
        pulse(0);
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if ({i0.done, i0.pass, i0.err_count, i0.err_flags} !== {1'b1, 1'b1, 8'd0, 5'd0}) begin
            failed++;
            $display("FAIL midrun_rerun got done=%b pass=%b err=%0d flags=%b, want 1 1 0 0", i0.done, i0.pass, i0.err_count, i0.err_flags);
        end
    endtask

    task automatic test_back_to_back;
        stuck0 = 1'b1;
        pulse(0);
        repeat (15) @(posedge clk);
        pulse(0);
        tests++;
        if ({i0.a, i0.b} !== 2'b01 || i0.busy !== 1'b1) begin
            failed++;
            $display("FAIL busy_start_ignored got ab=%b%b busy=%b, want 01 1", i0.a, i0.b, i0.busy);
        end
        repeat (22) @(posedge clk);
        #1;
        tests++;
        if (i0.busy !== 1'b1 || i0.done !== 1'b0 || {i0.a, i0.b} !== 2'b11) begin
            failed++;
            $display("FAIL busy_timing got busy=%b done=%b ab=%b%b, want 1 0 11", i0.busy, i0.done, i0.a, i0.b);
        end
        @(posedge clk);
        #1;
        tests++;
        if (i0.done !== 1'b1 || i0.err_count !== 8'd2) begin
            failed++;
            $display("FAIL busy_done got done=%b err=%0d, want 1 2", i0.done, i0.err_count);
        end
        stuck0 = 1'b0;
        pulse(0);
        tests++;
        if ({i0.busy, i0.done, i0.err_count, i0.err_flags, i0.fail_seen, i0.a, i0.b} !== {1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 2'b00}) begin
            failed++;
            $display("FAIL restart_clear got busy=%b done=%b err=%0d flags=%b seen=%b ab=%b%b, want 1 0 0 0 0 00",
                     i0.busy, i0.done, i0.err_count, i0.err_flags, i0.fail_seen, i0.a, i0.b);
        end
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (i0.done !== 1'b1 || i0.pass !== 1'b1) begin
            failed++;
            $display("FAIL restart_pass got done=%b pass=%b, want 1 1", i0.done, i0.pass);
        end
    endtask

    task automatic test_saturate;
        pulse(1);
        repeat (47) @(posedge clk);
        #1;
        tests++;
        if (i1.busy !== 1'b1 || i1.err_count !== 2'd3) begin
            failed++;
            $display("FAIL sat_running got busy=%b err=%0d, want 1 3", i1.busy, i1.err_count);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({i1.done, i1.pass, i1.err_count, i1.err_flags, i1.first_fail, i1.fail_seen} !== {1'b1, 1'b0, 2'd3, 5'b11111, 2'd0, 1'b1}) begin
            failed++;
            $display("FAIL sat_result got done=%b pass=%b err=%0d flags=%b first=%0d seen=%b, want 1 0 3 11111 0 1",
                     i1.done, i1.pass, i1.err_count, i1.err_flags, i1.first_fail, i1.fail_seen);
        end
    endtask

    task automatic test_short_hold;
        int n = 0;
        int bad = 0;
        pulse(2);
        while (i2.busy === 1'b1 && n < 100) begin
            if ({i2.a, i2.b} !== 2'((n / 2) % 4)) bad++;
            n++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (n !== 16) begin
            failed++;
            $display("FAIL short_busy_len got %0d cycles, want 16", n);
        end
        tests++;
        if (bad !== 0) begin
            failed++;
            $display("FAIL short_vectors got %0d wrong a/b cycles, want 0", bad);
        end
        tests++;
        if ({i2.done, i2.pass, i2.err_count} !== {1'b1, 1'b1, 8'd0}) begin
            failed++;
            $display("FAIL short_result got done=%b pass=%b err=%0d, want 1 1 0", i2.done, i2.pass, i2.err_count);
        end
    endtask

    initial begin
        i0.start = 1'b0;
        i1.start = 1'b0;
        i2.start = 1'b0;
        test_reset;
        test_golden;
        test_xor_stuck;
        test_reset_mid;
        test_back_to_back;
        test_saturate;
        test_short_hold;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
